// File: rtl/s641_bist_driver.sv
// BIST driver for the s641 netlist: a 35-bit LFSR feeds the netlist inputs and a 24-bit MISR
// compacts its outputs, sequenced by an IDLE/WARM/RUN/DONE controller.
module s641_bist_driver #(
  parameter int unsigned N_PAT  = 1000,
  parameter int unsigned WARMUP = 19,
  parameter logic [34:0] SEED   = 35'h0_0000_0001,
  parameter logic [23:0] GOLDEN = 24'h000000
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        START,
  input  logic [23:0] DUT_PO,
  output logic [34:0] DUT_PI,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [23:0] SIG
);

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_DONE} state_t;

  localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);
  localparam logic [15:0] RUN_LAST  = 16'(N_PAT - 1);

  state_t      state, nxt;
  logic [34:0] lfsr, lfsr_d, lfsr_step;
  logic [23:0] misr, misr_d, misr_step;
  logic [15:0] cnt, cnt_d;
  logic        pass_q, pass_d;

  // x^35+x^33+1 for stimulus, x^24+x^23+x^22+x^17+1 style feedback for compaction
  assign lfsr_step = {lfsr[33:0], lfsr[34] ^ lfsr[32]};
  assign misr_step = {misr[22:0], misr[23] ^ misr[22] ^ misr[21] ^ misr[16]} ^ DUT_PO;

  always_ff @(posedge CK) begin
    if (RST) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: if (START) nxt = (WARMUP == 0) ? S_RUN : S_WARM;
      S_WARM:         if (cnt == WARM_LAST) nxt = S_RUN;
      S_RUN:          if (cnt == RUN_LAST) nxt = S_DONE;
      default:        nxt = S_IDLE;
    endcase
  end

  // PASS is evaluated on the value the MISR is about to take, so it rises together with DONE
  always_comb begin
    lfsr_d = lfsr;
    misr_d = misr;
    cnt_d  = cnt;
    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          lfsr_d = SEED;
          misr_d = '0;
          cnt_d  = '0;
        end
      end
      S_WARM: begin
        lfsr_d = lfsr_step;
        cnt_d  = (cnt == WARM_LAST) ? 16'd0 : cnt + 16'd1;
      end
      S_RUN: begin
        lfsr_d = lfsr_step;
        misr_d = misr_step;
        cnt_d  = cnt + 16'd1;
      end
      default: ;
    endcase
    pass_d = (nxt == S_DONE) && (misr_d == GOLDEN);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      lfsr   <= SEED;
      misr   <= '0;
      cnt    <= '0;
      pass_q <= 1'b0;
    end else begin
      lfsr   <= lfsr_d;
      misr   <= misr_d;
      cnt    <= cnt_d;
      pass_q <= pass_d;
    end
  end

  always_comb begin
    BUSY   = (state == S_WARM) || (state == S_RUN);
    DONE   = (state == S_DONE);
    PASS   = pass_q;
    SIG    = misr;
    DUT_PI = lfsr;
  end

endmodule
